// File: rtl/seg_scan_driver.sv
`timescale 1ns/1ps
// Multiplexed seven-segment scanner: raw 8-bit patterns from a small buffer,
// per-digit blink, horizontal scrolling of long text and a frame-done strobe.
module seg_scan_driver #(
  parameter  int DIGITS        = 8,
  parameter  int REFRESH_DIV   = 200000,
  parameter  int BUF_DEPTH     = 16,
  parameter  int SCROLL_FRAMES = 64,
  parameter  int BLINK_FRAMES  = 32,
  localparam int AW            = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [AW:0]       text_len,
  input  logic              scroll_en,
  input  logic [DIGITS-1:0] blink_mask,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              frame_done
);

  localparam int CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SFW       = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam int BFW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int LW        = AW + 1;
  localparam int SW        = $clog2(BUF_DEPTH + DIGITS) + 1;
  localparam int MOD_STEPS = (BUF_DEPTH + DIGITS) / (DIGITS + 1) + 1;

  localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);
  localparam logic [SFW-1:0] SFR_LAST = SFW'(SCROLL_FRAMES - 1);
  localparam logic [BFW-1:0] BFR_LAST = BFW'(BLINK_FRAMES - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [SFW-1:0]    sfr_q, sfr_d;
  logic [AW-1:0]     off_q, off_d;
  logic [BFW-1:0]    bfr_q, bfr_d;
  logic              phase_q, phase_d;
  logic              run_q, tick_q, fd_q;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic [7:0]        buf_q [BUF_DEPTH];

  logic [LW-1:0]     eff_len;
  logic              scroll_act, tick, wrap, upd;
  logic [SW-1:0]     sum;
  logic [AW-1:0]     rd_addr;
  logic              shown, blank;
  logic [7:0]        pat;

  assign eff_len    = (text_len > LW'(BUF_DEPTH)) ? LW'(BUF_DEPTH) : text_len;
  assign scroll_act = scroll_en && (int'(eff_len) > DIGITS);
  assign tick       = enable && (cnt_q == CNT_LAST);
  assign wrap       = tick && (idx_q == IDX_LAST);
  // Outputs reload on the cycle after idx moves, or on the first enabled cycle.
  assign upd        = enable && (!run_q || tick_q);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sfr_d   = sfr_q;
    off_d   = off_q;
    bfr_d   = bfr_q;
    phase_d = phase_q;
    if (!enable) begin
      cnt_d   = '0;
      idx_d   = '0;
      sfr_d   = '0;
      off_d   = '0;
      bfr_d   = '0;
      phase_d = 1'b0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      if (wrap) begin
        // Offset only ever changes between frames, so a frame never tears.
        if (!scroll_act || ({1'b0, off_q} >= eff_len)) begin
          off_d = '0;
          sfr_d = '0;
        end else if (sfr_q == SFR_LAST) begin
          sfr_d = '0;
          off_d = ({1'b0, off_q} == eff_len - LW'(1)) ? '0 : off_q + 1'b1;
        end else begin
          sfr_d = sfr_q + 1'b1;
        end
        if (bfr_q == BFR_LAST) begin
          bfr_d   = '0;
          phase_d = !phase_q;
        end else begin
          bfr_d = bfr_q + 1'b1;
        end
      end
    end
  end

  // (offset + idx) mod L as a bounded compare-subtract chain.
  always_comb begin
    sum = SW'(off_q) + SW'(idx_q);
    for (int i = 0; i < MOD_STEPS; i++) begin
      if (sum >= SW'(eff_len)) sum = sum - SW'(eff_len);
    end
    rd_addr = scroll_act ? AW'(sum) : AW'(idx_q);
    shown   = scroll_act || (SW'(idx_q) < SW'(eff_len));
    pat     = shown ? buf_q[rd_addr] : 8'h00;
    blank   = phase_q && blink_mask[idx_q];
  end

  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (!enable) begin
      an_d  = '0;
      seg_d = 8'h00;
    end else if (upd) begin
      an_d         = '0;
      an_d[idx_q]  = 1'b1;
      seg_d        = blank ? 8'h00 : pat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      sfr_q   <= '0;
      off_q   <= '0;
      bfr_q   <= '0;
      phase_q <= 1'b0;
      run_q   <= 1'b0;
      tick_q  <= 1'b0;
      fd_q    <= 1'b0;
      an_q    <= '0;
      seg_q   <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sfr_q   <= sfr_d;
      off_q   <= off_d;
      bfr_q   <= bfr_d;
      phase_q <= phase_d;
      run_q   <= enable;
      tick_q  <= tick;
      fd_q    <= wrap;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  // NOTE: the buffer must read blank after reset, so it is built from resettable flops, not a RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= 8'h00;
    end else if (wr_en && ({1'b0, wr_addr} < LW'(BUF_DEPTH))) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
`timescale 1ns/1ps
// Bench for seg_scan_driver: vector table and frame model feed a slot scoreboard,
// plus hand-timed sequences for write hazard, enable drop and reset.
module tb_seg_scan_driver;

  localparam int DIGITS        = 4;
  localparam int REFRESH_DIV   = 4;
  localparam int BUF_DEPTH     = 8;
  localparam int SCROLL_FRAMES = 2;
  localparam int BLINK_FRAMES  = 1;
  localparam int AW            = 3;
  localparam int LW            = AW + 1;

  logic              clk = 1'b0;
  logic              reset, enable, wr_en, scroll_en;
  logic [AW-1:0]     wr_addr;
  logic [7:0]        wr_data;
  logic [AW:0]       text_len;
  logic [DIGITS-1:0] blink_mask;
  logic [7:0]        seg;
  logic [DIGITS-1:0] an;
  logic              frame_done;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .BUF_DEPTH(BUF_DEPTH),
    .SCROLL_FRAMES(SCROLL_FRAMES), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .text_len(text_len), .scroll_en(scroll_en),
    .blink_mask(blink_mask), .seg(seg), .an(an), .frame_done(frame_done)
  );

  typedef struct {
    logic [DIGITS-1:0] an;
    logic [7:0]        seg;
  } slot_t;

  typedef struct {
    int                  tl;
    bit                  sc;
    logic [DIGITS-1:0]   mask;
    logic [8*DIGITS-1:0] exp;
  } vec_t;

  slot_t             sb_q [$];
  slot_t             mon_e;
  vec_t              vecs [5];
  logic [7:0]        mem [BUF_DEPTH];
  logic [DIGITS-1:0] prev_an = '0;
  int                total = 0;
  int                bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each new lit digit is one scan slot; compare it against the next expectation.
  always @(negedge clk) begin
    if (reset && an != '0 && an != prev_an && sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("slot", 32'({an, seg}), 32'({mon_e.an, mon_e.seg}));
    end
    prev_an = an;
  end

  function automatic logic [7:0] model_seg(int f, int d, int tl, bit sc, logic [DIGITS-1:0] m);
    int len, off;
    bit ph, scr;
    len = (tl > BUF_DEPTH) ? BUF_DEPTH : tl;
    scr = sc && (len > DIGITS);
    off = scr ? (f / SCROLL_FRAMES) % len : 0;
    ph  = ((f / BLINK_FRAMES) % 2) == 1;
    if (ph && m[d]) return 8'h00;
    if (scr) return mem[(off + d) % len];
    if (d < len) return mem[d];
    return 8'h00;
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_buf(int a, logic [7:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    step(1);
    wr_en = 1'b0;
    mem[a] = d;
  endtask

  task automatic prep(int tl, bit sc, logic [DIGITS-1:0] m);
    enable = 1'b0; text_len = LW'(tl); scroll_en = sc; blink_mask = m;
    step(2);
  endtask

  task automatic push_slot(int d, logic [7:0] s);
    slot_t e;
    e.an  = DIGITS'(1) << d;
    e.seg = s;
    sb_q.push_back(e);
  endtask

  task automatic push_model(int frames, int tl, bit sc, logic [DIGITS-1:0] m);
    for (int f = 0; f < frames; f++)
      for (int d = 0; d < DIGITS; d++) push_slot(d, model_seg(f, d, tl, sc, m));
  endtask

  task automatic start_and_drain(int frames, string name);
    enable = 1'b1;
    for (int c = 0; c < frames * DIGITS * REFRESH_DIV + 20 && sb_q.size() > 0; c++) step(1);
    check({name, "_drain"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DIGITS-1:0] ea;
    reset = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = 8'h00;
    text_len = '0; scroll_en = 1'b0; blink_mask = '0;
    foreach (mem[i]) mem[i] = 8'h00;
    step(3);
    check("rst_an", 32'(an), 32'd0);
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    reset = 1'b1;
    step(2);

    write_buf(0, 8'h49); write_buf(1, 8'h0F); write_buf(2, 8'h77); write_buf(3, 8'h46);

    // Cycle-exact scan timing: 4-clock slots, frame_done once per 16 clocks.
    prep(4, 1'b0, '0);
    enable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      ea = DIGITS'(1) << (((k - 1) / REFRESH_DIV) % DIGITS);
      check("t_an", 32'(an), 32'(ea));
      check("t_seg", 32'(seg), 32'(mem[((k - 1) / REFRESH_DIV) % DIGITS]));
      check("t_fd", 32'(frame_done), (k % 16 == 0) ? 32'd1 : 32'd0);
    end

    // Static display vectors: digit 0 pattern in the low byte of exp.
    vecs = '{
      '{4,  1'b0, 4'b0000, 32'h46770F49},
      '{2,  1'b0, 4'b0000, 32'h00000F49},
      '{0,  1'b0, 4'b0000, 32'h00000000},
      '{4,  1'b1, 4'b0000, 32'h46770F49},
      '{15, 1'b0, 4'b0000, 32'h46770F49}
    };
    for (int i = 0; i < 5; i++) begin
      prep(vecs[i].tl, vecs[i].sc, vecs[i].mask);
      for (int f = 0; f < 2; f++)
        for (int d = 0; d < DIGITS; d++) push_slot(d, vecs[i].exp[8*d +: 8]);
      start_and_drain(2, "vec");
    end

    // Write landing on the same edge that loads digit 0: old value this scan, new one next scan.
    prep(4, 1'b0, '0);
    enable = 1'b1;
    step(16);
    check("wr_an3", 32'(an), 32'h8);
    check("wr_fd", 32'(frame_done), 32'd1);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h5A;
    step(1);
    wr_en = 1'b0;
    check("wr_an0", 32'(an), 32'h1);
    check("wr_old", 32'(seg), 32'h49);
    step(1);
    check("wr_hold", 32'(seg), 32'h49);
    step(15);
    check("wr_an0b", 32'(an), 32'h1);
    check("wr_new", 32'(seg), 32'h5A);
    mem[0] = 8'h5A;

    // Blink on digit 2 only, alternating every frame.
    prep(4, 1'b0, 4'b0100);
    push_model(4, 4, 1'b0, 4'b0100);
    start_and_drain(4, "blink");

    // Scroll of 6 characters, step every 2 frames, through a full wrap.
    write_buf(4, 8'hA1); write_buf(5, 8'hB2);
    prep(6, 1'b1, '0);
    push_model(14, 6, 1'b1, '0);
    start_and_drain(14, "scroll");

    // Scroll and blink together so steps and toggles share frame edges.
    prep(6, 1'b1, 4'b1001);
    push_model(6, 6, 1'b1, 4'b1001);
    start_and_drain(6, "combo");

    // Enable dropped on digit 2 mid-scroll, then restart at digit 0 with offset 0.
    prep(6, 1'b1, '0);
    push_model(5, 6, 1'b1, '0);
    start_and_drain(5, "pre_drop");
    for (int c = 0; c < 64 && an != 4'b0100; c++) step(1);
    check("drop_at_idx2", 32'(an), 32'h4);
    enable = 1'b0;
    step(1);
    check("drop_an", 32'(an), 32'd0);
    check("drop_seg", 32'(seg), 32'd0);
    prep(6, 1'b1, '0);
    push_model(3, 6, 1'b1, '0);
    start_and_drain(3, "restart");

    // Reset mid-scroll: immediate clear, write during reset ignored, buffer blank after.
    prep(6, 1'b1, '0);
    push_model(3, 6, 1'b1, '0);
    start_and_drain(3, "pre_rst");
    step(2);
    reset = 1'b0;
    #1;
    check("mrst_an", 32'(an), 32'd0);
    check("mrst_seg", 32'(seg), 32'd0);
    check("mrst_fd", 32'(frame_done), 32'd0);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'hEE;
    step(2);
    wr_en = 1'b0;
    foreach (mem[i]) mem[i] = 8'h00;
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check("post_rst_an", 32'(an), (k <= REFRESH_DIV) ? 32'h1 : 32'h2);
      check("post_rst_seg", 32'(seg), 32'd0);
    end
    prep(8, 1'b0, '0);
    push_model(1, 8, 1'b0, '0);
    start_and_drain(1, "blank_buf");

    // Full 8-entry scroll with text_len above the buffer depth, plus blink on digit 1.
    write_buf(0, 8'h3F); write_buf(1, 8'h06); write_buf(2, 8'h5B); write_buf(3, 8'h4F);
    write_buf(4, 8'h66); write_buf(5, 8'h6D); write_buf(6, 8'h7D); write_buf(7, 8'h07);
    prep(12, 1'b1, 4'b0010);
    push_model(18, 12, 1'b1, 4'b0010);
    start_and_drain(18, "scroll8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised multiplexed seven-segment driver for the board display.
- Scans DIGITS active-high anodes from an internal character buffer holding raw 8-bit segment patterns.
- Adds per-digit blink, text longer than the display with horizontal scrolling, and a frame-done strobe for the game/menu controllers.
- Sits between the mode/score logic, which writes patterns, and the physical seg/an pins.

Parameters:
DIGITS, 8, number of scanned digits (width of an).
REFRESH_DIV, 200000, clk cycles each digit stays lit.
BUF_DEPTH, 16, character buffer entries.
SCROLL_FRAMES, 64, full scan frames per one-character scroll step.
BLINK_FRAMES, 32, full scan frames per blink half-period.
AW, $clog2(BUF_DEPTH), buffer address width (derived, not overridden).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  display on; low blanks the outputs and restarts the scan
wr_en  in  1  buffer write strobe
wr_addr  in  AW  buffer write address
wr_data  in  8  segment pattern to store (bit=1 lit)
text_len  in  AW+1  number of valid characters in buffer
scroll_en  in  1  scroll text when text_len > DIGITS
blink_mask  in  DIGITS  bit d=1 makes digit d blink
seg  out  8  segment pattern of the lit digit
an  out  DIGITS  one-hot active-high digit select
frame_done  out  1  one-cycle pulse at end of each full scan frame

Behaviour:
Reset (reset=0, asynchronous):
- seg=8'h00, an=0, frame_done=0.
- All counters, scroll offset, blink phase and digit index cleared to 0.
- Every buffer entry cleared to 8'h00 (blank).

Refresh counter:
- Counts 0..REFRESH_DIV-1 and wraps.
- tick = (counter == REFRESH_DIV-1).

Digit index:
- idx increments on tick and wraps DIGITS-1 -> 0.
- frame_done=1 for exactly the cycle following the tick that wraps idx to 0.

Outputs:
- Registered, one-cycle latency. On the cycle after idx changes, an = 1<<idx and seg = pattern(idx).

Effective length:
- L = min(text_len, BUF_DEPTH).
- L=0 -> all digits blank.

Pattern selection:
- pattern(d) = buf[(offset+d) mod L] when scrolling is active.
- Otherwise pattern(d) = buf[d] if d<L, else 8'h00.
- Digit 0 shows the first character.

Scrolling:
- Active only when scroll_en=1 and L>DIGITS.
- Frame counter increments on each frame_done event.
- After SCROLL_FRAMES frames, offset = offset+1, wrapping L-1 -> 0.
- When scrolling becomes inactive (scroll_en low or L<=DIGITS), offset returns to 0 at the next frame boundary, never mid-frame.
- If L shrinks so that offset >= L, offset is forced to 0 at the next frame boundary.

Blink:
- Phase toggles every BLINK_FRAMES frames.
- While phase=1, digits with blink_mask[d]=1 output seg=8'h00; an is still driven.
- blink_mask=0 disables blink; the phase keeps running.

Buffer write port:
- Write on wr_en at any time; no handshake, always accepted.
- Data is visible on seg from the next scan of that digit.
- wr_addr >= BUF_DEPTH is ignored.
- A write in the same cycle as the read of that address: seg shows the old value this cycle and the new value on the next scan.

Enable:
- enable=0: an=0 and seg=0 on the next cycle; refresh counter, idx, scroll and blink counters held at 0; buffer writes still accepted.
- Rising enable restarts at idx=0, offset=0, phase=0.

Simultaneous events:
- frame_done, scroll step and blink toggle may coincide; all apply on the same edge.
- Reset asserted mid-frame clears immediately; the first tick after release occurs REFRESH_DIV cycles later.

Test Plan:
1. DIGITS=4, REFRESH_DIV=4, write buf[0..3]=8'h49,8'h0F,8'h77,8'h46, text_len=4, enable=1 -> an cycles 0001,0010,0100,1000 every 4 clocks with seg 49,0F,77,46; frame_done pulses once per 16 clocks.
2. text_len=2 after test 1 -> digits 2 and 3 show seg=8'h00 while an still scans; text_len=0 -> seg=8'h00 on all digits.
3. BUF_DEPTH=8, text_len=6, scroll_en=1, SCROLL_FRAMES=2 -> digit 0 shows buf[0], buf[1] ... buf[5], then buf[0] again, advancing every 2 frames; with offset=4, digit 3 shows buf[1].
4. blink_mask=4'b0100, BLINK_FRAMES=1 -> digit 2 seg alternates pattern and 8'h00 on successive frames; other digits are steady.
5. enable dropped mid-frame at idx=2 -> an=0 and seg=0 next cycle; re-enable -> scan restarts at an=0001 with offset 0.
6. reset pulsed low mid-scroll -> outputs go to 0 immediately and the buffer reads all 8'h00 after release; a write during reset is ignored.
